enable_sequence_checker: RTL
============================

# enable_sequence_checker

In-design checker directly downstream of the enable controller. It consumes the ten one-hot-style enable strobes and tracks their progress through the 10-cycle frame. It counts completed frames and latches a sticky error on the first deviation from the legal pattern. Its status outputs go to the debug/status register bank and are also sampled by the UVM monitor as a cross-check.

## Interface
Parameters:
- CNT_W, default 16: width of the completed-frame counter.
- TIMEOUT_CYC, default 32: maximum number of idle cycles allowed between frames. Used only when ENABLE_SEQ_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- reset_i  input  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to clk_i via the standard 2-flop synchronizer.
- clear_i  input  1  synchronous clear of error, counter and FSM.
- enable_i  input  10  enable strobes; bit 0 = enable1 … bit 9 = enable10.
- busy_o  output  1  FSM is in TRACK.
- phase_o  output  4  next expected phase, 0..9.
- frame_done_o  output  1  one-cycle pulse when a frame completes legally.
- frame_count_o  output  CNT_W  completed frames; saturates at all-ones.
- error_o  output  1  sticky error flag.
- err_phase_o  output  4  phase at which the error was detected.
- err_code_o  output  2  error cause: 00 none, 01 pattern mismatch, 10 idle timeout, 11 dropout (all-zero inside a frame).

## Operation
- Expected pattern EXP(p) for phase p:
  - p0 = {e1}
  - p1 = {e2}
  - p2 = {e3}
  - p3 = {e3, e4}
  - p4..p9 = {e5}..{e10}, one bit each.
  - Comparison is exact equality on all 10 bits.
- FSM has three states: IDLE, TRACK, ERROR. Reset state is IDLE with phase 0.
- IDLE:
  - enable_i == 0: stay in IDLE.
  - enable_i == EXP(0): go to TRACK, phase = 1.
  - any other value: go to ERROR with code 01, err_phase 0.
- TRACK at phase p:
  - enable_i == EXP(p) and p < 9: phase = p+1.
  - enable_i == EXP(9) at p = 9: pulse frame_done_o, increment frame_count_o (saturating), phase = 0, go to IDLE.
  - enable_i == 0: go to ERROR with code 11, err_phase = p.
  - any other value: go to ERROR with code 01, err_phase = p.
- Back-to-back frames are legal: IDLE accepts EXP(0) on the cycle after p9 completes, with no gap required.
- ERROR:
  - Sticky; enable_i is ignored.
  - error_o, err_code_o and err_phase_o hold their values.
  - frame_count_o freezes.
  - Only clear_i or reset exits this state.
- clear_i, in any state:
  - Next state is IDLE with phase 0.
  - frame_count_o = 0, error_o = 0, err_code_o = 00, err_phase_o = 0.
  - clear_i has priority over enable_i in the same cycle; that cycle's enable_i is discarded.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The first frame after reset must start at EXP(0).
- Only the first error is recorded; later deviations do not overwrite it.

## Timing
- All outputs are registered. A response appears on the cycle after the posedge at which enable_i was sampled (latency 1).
- frame_done_o is high for exactly one cycle: the cycle after EXP(9) is sampled. frame_count_o updates in that same cycle.
- error_o rises one cycle after the offending sample.
- Reset values of all outputs are 0: busy_o, phase_o, frame_done_o, frame_count_o, error_o, err_phase_o, err_code_o.
- At saturation, frame_count_o stays at all-ones, while frame_done_o still pulses.

## Configuration
- ENABLE_SEQ_TIMEOUT_EN defined:
  - An 8-bit idle counter runs while in IDLE, but only after at least one frame has completed since the last reset or clear.
  - The counter resets on entry to TRACK.
  - When it reaches TIMEOUT_CYC, the FSM goes to ERROR with code 10 and err_phase 0.
- ENABLE_SEQ_TIMEOUT_EN undefined:
  - No idle counter is built and IDLE may last indefinitely.
  - err_code_o never takes value 10.

## Test plan
- Three back-to-back legal frames after reset release:
  - frame_done_o pulses 3 times, spaced 10 cycles apart.
  - frame_count_o = 3; error_o = 0.
- One legal frame, then at phase 5 drive {e5, e7}:
  - Next cycle: error_o = 1, err_code_o = 01, err_phase_o = 5.
  - frame_count_o stays at 1 despite further frames.
- Drive all-zero at phase 3:
  - Error with err_code_o = 11, err_phase_o = 3.
- Assert clear_i in ERROR together with EXP(0):
  - Next cycle: IDLE, error_o = 0, frame_count_o = 0, busy_o = 0. That cycle's EXP(0) is ignored.
- Assert reset_i low at phase 7:
  - All outputs are 0 immediately.
  - After release, a frame starting at EXP(0) completes with frame_count_o = 1.
- With ENABLE_SEQ_TIMEOUT_EN and TIMEOUT_CYC = 4, one frame followed by idle:
  - Error with code 10 after 4 idle cycles.
  - Without the macro, 100 idle cycles produce no error.

Source files
------------

// File: rtl/enable_sequence_checker.sv
// enable_sequence_checker: tracks the ten enable strobes through the
// 10-cycle frame, counts legal frames, and latches the first deviation.
//
// Ports:
//   clk_i          clock; all logic on posedge
//   reset_i        async active-low reset; deasserted via a 2-flop sync
//   clear_i        sync clear of error, counter and FSM
//   enable_i[9:0]  enable strobes, bit 0 = enable1 .. bit 9 = enable10
//   busy_o         FSM is in TRACK
//   phase_o[3:0]   next expected phase, 0..9
//   frame_done_o   one-cycle pulse on legal frame completion
//   frame_count_o  completed frames, saturating
//   error_o        sticky error flag
//   err_phase_o    phase at which the error was detected
//   err_code_o     00 none, 01 mismatch, 10 idle timeout, 11 dropout
//
// Optional feature: define ENABLE_SEQ_TIMEOUT_EN to build the idle
// timeout (TIMEOUT_CYC idle cycles after the first completed frame).

module enable_sequence_checker #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic [9:0]       enable_i,
    output logic             busy_o,
    output logic [3:0]       phase_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_count_o,
    output logic             error_o,
    output logic [3:0]       err_phase_o,
    output logic [1:0]       err_code_o
);

    // Elaboration-time range check on the timeout parameter.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_DROPOUT  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------
    // Reset synchronizer: assert asynchronously, release on clk_i.
    // ------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------
    // Expected pattern per phase. Phase 3 keeps enable3 high while
    // enable4 joins; every other phase is a single strobe.
    // ------------------------------------------------------------
    function automatic logic [9:0] exp_pat(input logic [3:0] p);
        logic [9:0] r;
        r = 10'd0;
        case (p)
            4'd0:    r = 10'b00_0000_0001;
            4'd1:    r = 10'b00_0000_0010;
            4'd2:    r = 10'b00_0000_0100;
            4'd3:    r = 10'b00_0000_1100;
            4'd4:    r = 10'b00_0001_0000;
            4'd5:    r = 10'b00_0010_0000;
            4'd6:    r = 10'b00_0100_0000;
            4'd7:    r = 10'b00_1000_0000;
            4'd8:    r = 10'b01_0000_0000;
            4'd9:    r = 10'b10_0000_0000;
            default: r = 10'd0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------
    state_t           state_q;
    logic [3:0]       phase_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic             error_q;
    logic [3:0]       err_phase_q;
    logic [1:0]       err_code_q;

    logic [9:0]       exp_cur;
    logic             hit_cur;
    logic             hit_first;
    logic             is_zero;
    logic             last_phase;
    logic [CNT_W-1:0] count_d;

    assign exp_cur    = exp_pat(phase_q);
    assign hit_cur    = (enable_i == exp_cur);
    assign hit_first  = (enable_i == exp_pat(4'd0));
    assign is_zero    = (enable_i == 10'd0);
    assign last_phase = (phase_q == 4'd9);

    // Saturating increment of the completed-frame counter.
    assign count_d = (count_q == CNT_MAX) ? count_q
                                          : count_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ENABLE_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    // seen_q: a frame has completed since the last reset/clear, which
    // arms the idle counter.
    logic       seen_q;
    logic [7:0] idle_q;
    logic [7:0] idle_d;

    assign idle_d = idle_q + 8'd1;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            error_q     <= 1'b0;
            err_phase_q <= 4'd0;
            err_code_q  <= ERR_NONE;
`ifdef ENABLE_SEQ_TIMEOUT_EN
            seen_q      <= 1'b0;
            idle_q      <= 8'd0;
`endif
        end else begin
            done_q <= 1'b0;
            if (clear_i) begin
                // Clear wins over enable_i; that sample is dropped.
                state_q     <= ST_IDLE;
                phase_q     <= 4'd0;
                busy_q      <= 1'b0;
                count_q     <= '0;
                error_q     <= 1'b0;
                err_phase_q <= 4'd0;
                err_code_q  <= ERR_NONE;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                seen_q      <= 1'b0;
                idle_q      <= 8'd0;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (is_zero) begin
`ifdef ENABLE_SEQ_TIMEOUT_EN
                            if (seen_q) begin
                                if (idle_d == TO_LIM) begin
                                    state_q     <= ST_ERROR;
                                    error_q     <= 1'b1;
                                    err_code_q  <= ERR_TIMEOUT;
                                    err_phase_q <= 4'd0;
                                end else begin
                                    idle_q <= idle_d;
                                end
                            end
`endif
                        end else if (hit_first) begin
                            state_q <= ST_TRACK;
                            phase_q <= 4'd1;
                            busy_q  <= 1'b1;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                            idle_q  <= 8'd0;
`endif
                        end else begin
                            state_q     <= ST_ERROR;
                            error_q     <= 1'b1;
                            err_code_q  <= ERR_MISMATCH;
                            err_phase_q <= 4'd0;
                        end
                    end

                    ST_TRACK: begin
                        if (hit_cur && last_phase) begin
                            state_q <= ST_IDLE;
                            phase_q <= 4'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            count_q <= count_d;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                            seen_q  <= 1'b1;
                            idle_q  <= 8'd0;
`endif
                        end else if (hit_cur) begin
                            phase_q <= phase_q + 4'd1;
                        end else begin
                            state_q     <= ST_ERROR;
                            busy_q      <= 1'b0;
                            error_q     <= 1'b1;
                            err_phase_q <= phase_q;
                            err_code_q  <= is_zero ? ERR_DROPOUT
                                                   : ERR_MISMATCH;
                        end
                    end

                    ST_ERROR: begin
                        // Sticky: everything holds until clear/reset.
                        state_q <= ST_ERROR;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        phase_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o        = busy_q;
    assign phase_o       = phase_q;
    assign frame_done_o  = done_q;
    assign frame_count_o = count_q;
    assign error_o       = error_q;
    assign err_phase_o   = err_phase_q;
    assign err_code_o    = err_code_q;

endmodule
